// File: rtl/sopc_mem_arbiter.sv
// Arbitrates the single-port SOPC RAM between instruction fetch and the MEM stage.
// MEM has priority; IF is forced through after STARVE_LIMIT consecutive MEM grants.
module sopc_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [3:0]            mem_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ack,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [3:0]            ram_sel,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  stallreq
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic          store_q;
  logic          if_elig, mem_elig;
  logic          grant_if, grant_mem;

  // Handshake: a requester holds req (and its address/data) until it sees a
  // one-cycle ack; during that ack cycle its still-high req is ignored.
  assign if_elig  = if_req  & ~if_ack;
  assign mem_elig = mem_req & ~mem_ack;
  assign stallreq = (if_req & ~if_ack) | (mem_req & ~mem_ack);

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    starve_nxt = starve_cnt;
    grant_if   = 1'b0;
    grant_mem  = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && starve_cnt == LIMIT) grant_if = 1'b1;
        else if (mem_elig)                  grant_mem = 1'b1;
        else if (if_elig)                   grant_if = 1'b1;
        if (grant_if || grant_mem) begin
          state_nxt = ACCESS;
          owner_nxt = grant_if ? OWN_IF : OWN_MEM;
          if (grant_mem && if_req)
            starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + CW'(1);
          else
            starve_nxt = '0;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_sel   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            ram_ce   <= 1'b1;
            ram_we   <= 1'b0;
            ram_sel  <= 4'b1111;
            ram_addr <= if_addr;
            store_q  <= 1'b0;
          end else if (grant_mem) begin
            ram_ce    <= 1'b1;
            ram_we    <= mem_we;
            ram_sel   <= mem_sel;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            store_q   <= mem_we;
          end
        end
        ACCESS: begin
          ram_ce <= 1'b0;
          ram_we <= 1'b0;
        end
        RESP: begin
          if (owner == OWN_IF) begin
            if_rdata <= ram_rdata;
            if_ack   <= 1'b1;
          end else if (owner == OWN_MEM) begin
            // Stores leave the last load result visible on mem_rdata.
            if (!store_q) mem_rdata <= ram_rdata;
            mem_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
